// File: rtl/counter_seq_pkg.sv
// Shared types and the hex-to-segment table for the counter sequencer.
// Segment codes are active-high, bit 0 = segment a.
package counter_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD,
        CMD_UP,
        CMD_DOWN,
        CMD_STOP
    } cmd_t;

    localparam logic [7:0] SEG_RESET = 8'h3F;

    function automatic logic [6:0] seg7_hex(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h67;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/counter_sequencer_seg7_register.sv
// Registered 7-segment image: hex code of value plus a decimal-point bit.
// Clears to the "0" glyph so the display is sane straight out of reset.
module seg7_register
    import counter_seq_pkg::*;
#(
    parameter int NBITS_SEG = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [3:0]           value,
    input  logic                 dp,
    output logic [NBITS_SEG-1:0] seg
);

    logic [7:0] image;

    assign image = {dp, seg7_hex(value)};

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            seg <= NBITS_SEG'(SEG_RESET);
        end else begin
            seg <= NBITS_SEG'(image);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven 4-bit up/down counter with load, terminal detect, auto-reload,
// a clock-enable prescaler and a registered 7-segment view of the count.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int PRESC     = 4,
    parameter int NBITS_SEG = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd,
    input  logic [3:0]           cmd_data,
    input  logic [3:0]           limit,
    input  logic                 auto_reload,
    output logic                 cmd_ready,
    output logic [3:0]           count,
    output logic                 running,
    output logic                 dir,
    output logic                 done,
    output logic [NBITS_SEG-1:0] SEG
);

    localparam logic [7:0] PRESC_LAST = 8'(PRESC - 1);

    state_t     state;
    logic [3:0] base;
    logic [7:0] presc;
    logic       accept;
    logic       step;
    logic       at_limit;
    logic       at_base;

    assign cmd_ready = (state != S_LOAD);
    assign running   = (state == S_UP) || (state == S_DOWN);
    assign accept    = cmd_valid && cmd_ready;
    assign step      = running && (presc == PRESC_LAST);
    assign at_limit  = (count == limit);
    assign at_base   = (count == base);

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            count <= 4'd0;
            base  <= 4'd0;
            presc <= 8'd0;
            dir   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (running) begin
                presc <= step ? 8'd0 : presc + 8'd1;
            end

            if (state == S_LOAD) begin
                state <= S_IDLE;
            end else if (accept) begin
                // A command on a step cycle pre-empts the step and its done pulse.
                case (cmd_t'(cmd))
                    CMD_LOAD: begin
                        base  <= cmd_data;
                        count <= cmd_data;
                        state <= S_LOAD;
                    end
                    CMD_UP: begin
                        dir   <= 1'b0;
                        presc <= 8'd0;
                        state <= S_UP;
                    end
                    CMD_DOWN: begin
                        dir   <= 1'b1;
                        presc <= 8'd0;
                        state <= S_DOWN;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end else if (step) begin
                if (state == S_UP) begin
                    if (at_limit) begin
                        done <= 1'b1;
                        if (auto_reload) begin
                            count <= base;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        count <= count + 4'd1;
                    end
                end else begin
                    if (at_base) begin
                        done <= 1'b1;
                        if (auto_reload) begin
                            count <= limit;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
            end
        end
    end

    seg7_register #(
        .NBITS_SEG(NBITS_SEG)
    ) u_seg (
        .clk_2(clk_2),
        .reset(reset),
        .value(count),
        .dp   (running & dir),
        .seg  (SEG)
    );

endmodule

// File: tb/tb_counter_sequencer.sv
// Two sequencers (PRESC=1 and PRESC=2) share one stimulus stream and are each
// compared every cycle against a plain-arithmetic model of the command rules.
module tb_counter_sequencer;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [3:0] limit = 4'd0;
    logic       auto_reload = 1'b0;

    logic [1:0]      rdy, run, dr, dn;
    logic [1:0][3:0] cnt;
    logic [1:0][7:0] seg;

    int checks = 0;
    int errors = 0;

    always #5 clk_2 = ~clk_2;

    counter_sequencer #(.PRESC(1), .NBITS_SEG(8)) u_p1 (
        .clk_2(clk_2), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_data(cmd_data), .limit(limit), .auto_reload(auto_reload),
        .cmd_ready(rdy[0]), .count(cnt[0]), .running(run[0]), .dir(dr[0]),
        .done(dn[0]), .SEG(seg[0])
    );

    counter_sequencer #(.PRESC(2), .NBITS_SEG(8)) u_p2 (
        .clk_2(clk_2), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_data(cmd_data), .limit(limit), .auto_reload(auto_reload),
        .cmd_ready(rdy[1]), .count(cnt[1]), .running(run[1]), .dir(dr[1]),
        .done(dn[1]), .SEG(seg[1])
    );

    // Model modes: 0 idle, 1 load, 2 up, 3 down, 4 done.
    int pr[2] = '{1, 2};
    int hex_tab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                        'h7F, 'h67, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
    int m_st[2], m_cnt[2], m_base[2], m_pre[2], m_dir[2], m_done[2], m_seg[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_base[k] = 0; m_pre[k] = 0;
            m_dir[k] = 0; m_done[k] = 0; m_seg[k] = 'h3F;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit is_run;
            is_run = (m_st[k] == 2) || (m_st[k] == 3);
            m_seg[k] = ((is_run && m_dir[k] == 1) ? 128 : 0) + hex_tab[m_cnt[k]];
            m_done[k] = 0;
            if (m_st[k] == 1) begin
                m_st[k] = 0;
            end else if (cmd_valid) begin
                case (int'(cmd))
                    0: begin m_base[k] = int'(cmd_data); m_cnt[k] = int'(cmd_data); m_st[k] = 1; end
                    1: begin m_dir[k] = 0; m_pre[k] = 0; m_st[k] = 2; end
                    2: begin m_dir[k] = 1; m_pre[k] = 0; m_st[k] = 3; end
                    default: m_st[k] = 0;
                endcase
            end else if (is_run) begin
                if (m_pre[k] == pr[k] - 1) begin
                    m_pre[k] = 0;
                    if (m_st[k] == 2) begin
                        if (m_cnt[k] == int'(limit)) begin
                            m_done[k] = 1;
                            if (auto_reload) m_cnt[k] = m_base[k];
                            else m_st[k] = 4;
                        end else m_cnt[k] = (m_cnt[k] + 1) % 16;
                    end else begin
                        if (m_cnt[k] == m_base[k]) begin
                            m_done[k] = 1;
                            if (auto_reload) m_cnt[k] = int'(limit);
                            else m_st[k] = 4;
                        end else m_cnt[k] = (m_cnt[k] + 15) % 16;
                    end
                end else begin
                    m_pre[k] = m_pre[k] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[presc=%0d] got %0h expected %0h", tag, pr[k], obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk("count", k, 32'(cnt[k]), m_cnt[k]);
            chk("cmd_ready", k, 32'(rdy[k]), (m_st[k] != 1) ? 1 : 0);
            chk("running", k, 32'(run[k]), (m_st[k] == 2 || m_st[k] == 3) ? 1 : 0);
            chk("dir", k, 32'(dr[k]), m_dir[k]);
            chk("done", k, 32'(dn[k]), m_done[k]);
            chk("SEG", k, 32'(seg[k]), m_seg[k]);
        end
    endtask

    task automatic tick_chk();
        model_edge();
        @(posedge clk_2);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [1:0] c, input logic [3:0] d);
        cmd_valid = 1'b1; cmd = c; cmd_data = d;
        tick_chk();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int pulses [2];
        int exp_cnt[4];
        int exp_dn [4];
        int saved;

        // Reset state, checked while reset is still asserted and after release.
        #12;
        model_reset();
        compare_all();
        reset = 1'b1;
        tick_chk();
        chk("rst_seg_const", 1, 32'(seg[1]), 32'h3F);

        // Load 3 then count up to limit 5, no reload.
        limit = 4'd5; auto_reload = 1'b0;
        send(2'd0, 4'd3);
        tick_chk();
        send(2'd1, 4'd0);
        pulses = '{0, 0};
        for (int i = 0; i < 12; i++) begin
            tick_chk();
            for (int k = 0; k < 2; k++) pulses[k] += int'(dn[k]);
        end
        for (int k = 0; k < 2; k++) begin
            chk("up_done_pulses", k, pulses[k], 1);
            chk("up_final_count", k, 32'(cnt[k]), 32'd5);
            chk("up_final_seg", k, 32'(seg[k]), 32'h6D);
        end

        // Down with auto-reload on the PRESC=1 instance.
        send(2'd3, 4'd0);
        limit = 4'd4; auto_reload = 1'b1;
        send(2'd0, 4'd2);
        tick_chk();
        send(2'd2, 4'd0);
        exp_cnt = '{4, 3, 2, 4};
        exp_dn  = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            tick_chk();
            chk("down_count", 0, 32'(cnt[0]), exp_cnt[i]);
            chk("down_done", 0, 32'(dn[0]), exp_dn[i]);
            chk("down_seg_dp", 0, 32'(seg[0][7]), 32'd1);
        end

        // Up-count wrap from 14 through 0 to limit 1.
        send(2'd3, 4'd0);
        limit = 4'd1; auto_reload = 1'b0;
        send(2'd0, 4'd14);
        tick_chk();
        send(2'd1, 4'd0);
        exp_cnt = '{15, 0, 1, 1};
        exp_dn  = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            tick_chk();
            chk("wrap_count", 0, 32'(cnt[0]), exp_cnt[i]);
            chk("wrap_done", 0, 32'(dn[0]), exp_dn[i]);
        end

        // STOP arriving exactly on a step cycle of the PRESC=2 instance.
        limit = 4'd15;
        send(2'd0, 4'd7);
        tick_chk();
        send(2'd1, 4'd0);
        for (int i = 0; i < 4; i++) if (m_pre[1] != 1) tick_chk();
        chk("coll_presc_reached", 1, m_pre[1], 1);
        saved = m_cnt[1];
        send(2'd3, 4'd0);
        chk("coll_count", 1, 32'(cnt[1]), saved);
        chk("coll_done", 1, 32'(dn[1]), 32'd0);
        chk("coll_running", 1, 32'(run[1]), 32'd0);

        // Asynchronous reset mid-run at count 9 while a LOAD is offered.
        send(2'd0, 4'd9);
        tick_chk();
        send(2'd1, 4'd0);
        cmd_valid = 1'b1; cmd = 2'd0; cmd_data = 4'd5;
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("arst_seg", 1, 32'(seg[1]), 32'h3F);
        @(posedge clk_2);
        #1;
        compare_all();
        cmd_valid = 1'b0;
        #3 reset = 1'b1;
        tick_chk();
        chk("arst_load_ignored", 1, 32'(cnt[1]), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd = 2'($urandom_range(0, 3));
            cmd_data = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) limit = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) auto_reload = ~auto_reload;
            tick_chk();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Command-driven controller that sequences a 4-bit up/down counter datapath with parallel load, terminal-value detection and optional auto-reload.
- Accepts commands over a valid/ready handshake and paces counting with an internal clock-enable prescaler.
- Drives a registered 7-segment image of the count.
- Sits between board-level switch/command logic and the SEG/LED outputs of top.

Parameters:
- PRESC, 4: counter steps once every PRESC clk_2 cycles while running; legal range 1..255.
- NBITS_SEG, 8: width of the 7-segment output.

Ports:
- clk_2  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd  input  2  0=LOAD, 1=UP, 2=DOWN, 3=STOP.
- cmd_data  input  4  base value for LOAD; ignored otherwise.
- limit  input  4  upper terminal value; sampled live at every step.
- auto_reload  input  1  at terminal: 1 reloads and keeps running, 0 stops.
- cmd_ready  output  1  command accepted this cycle when cmd_valid && cmd_ready.
- count  output  4  current count.
- running  output  1  high in S_UP or S_DOWN.
- dir  output  1  1=down, 0=up; holds its last value when not running.
- done  output  1  one-cycle pulse on each terminal event.
- SEG  output  8  registered 7-segment image of count.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_IDLE; count=0; base=0; presc=0; dir=0; done=0; SEG=8'h3F.
  - All registers use an asynchronous clear, with release synchronous to clk_2.
- States are S_IDLE, S_LOAD, S_UP, S_DOWN, S_DONE.
- cmd_ready:
  - Low in S_LOAD.
  - High in all other states.
- Accepted commands, from any ready state:
  - LOAD: base<=cmd_data; count<=cmd_data; go to S_LOAD.
  - UP: dir<=0; presc<=0; go to S_UP.
  - DOWN: dir<=1; presc<=0; go to S_DOWN.
  - STOP: go to S_IDLE; count is held.
- S_LOAD lasts exactly one cycle and then moves to S_IDLE.
- Prescaler: in S_UP or S_DOWN, presc increments each cycle; a step occurs when presc==PRESC-1, and presc then returns to 0.
- Step in S_UP:
  - If count==limit: pulse done. If auto_reload=1, count<=base and stay in S_UP; otherwise go to S_DONE with count held.
  - Otherwise count<=count+1, wrapping 15->0. If base>limit, the count passes through the wrap before reaching limit.
- Step in S_DOWN:
  - If count==base: pulse done. If auto_reload=1, count<=limit and stay in S_DOWN; otherwise go to S_DONE.
  - Otherwise count<=count-1, wrapping 0->15.
- S_DONE: count is held; the block waits for a command.
- Simultaneous accepted command and step: the command wins. The step and the done pulse are suppressed that cycle.
- done is registered and asserted in the same cycle the terminal step is applied. It is never high two cycles in a row unless PRESC=1.
- SEG:
  - SEG[6:0] is the registered hex segment code of count, one cycle behind count.
  - Codes: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:67 A:77 B:7C C:39 D:5E E:79 F:71.
  - SEG[7] = running & dir (shown as SEG bit 7 combined with the code, e.g. 8'h3F).
- Reset during operation: takes effect immediately; any in-flight command is discarded.

Decomposition:
- Package counter_seq_pkg:
  - state_t enum {S_IDLE, S_LOAD, S_UP, S_DOWN, S_DONE}.
  - cmd_t enum {CMD_LOAD, CMD_UP, CMD_DOWN, CMD_STOP}.
  - Function seg7_hex(4-bit) returning the 7-bit segment code.
- One sub-module, seg7_register: registered hex-to-segment stage with asynchronous active-low clear to 8'h3F.

Test Plan:
- Reset check: after reset release -> count=0, SEG=8'h3F, cmd_ready=1, running=0, done=0.
- Load then count up (PRESC=2): LOAD cmd_data=3, then UP with limit=5, auto_reload=0 -> count 3,4,5 at steps spaced 2 cycles; done pulses once when count==5; state S_DONE; SEG=8'h6D one cycle later.
- Count down with reload (PRESC=1): LOAD 2, then DOWN, limit=4, auto_reload=1 -> count 2,1... terminal at count==2 immediately gives done and reload to 4, then 3,2 with done again; SEG[7]=1 throughout.
- Up-count wrap: base=14, limit=1, UP -> count sequence 14,15,0,1, then done.
- Command collision: issue STOP on the exact cycle presc==PRESC-1 -> no step, no done, state S_IDLE, count unchanged.
- Mid-run reset: assert reset asynchronously between clock edges while in S_UP at count=9 -> outputs clear immediately to reset values; a LOAD presented the same cycle is ignored.
